// File: rtl/ot_write_mb.sv
// Multi-bank, multi-round output writer: pops result words from the output FIFO
// and writes them into one of NUM_BANK output SRAM banks under a start/busy/done job handshake.
module ot_write_mb #(
  parameter int unsigned SRAM_DATA_BITS = 64,
  parameter int unsigned SRAM_ADDR_BITS = 10,
  parameter int unsigned NUM_BANK       = 2,
  parameter int unsigned BANK_IDX_BITS  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  input  logic [SRAM_DATA_BITS-1:0] data_in,
  input  logic                      fifo_empty_n,
  output logic                      fifo_read,
  output logic [NUM_BANK-1:0]       cen_otsr,
  output logic [NUM_BANK-1:0]       wen_otsr,
  output logic [SRAM_ADDR_BITS-1:0] addr_otsr,
  output logic [SRAM_DATA_BITS-1:0] data_for_sram,
  output logic                      last,
  input  logic [SRAM_ADDR_BITS-1:0] cfg_ot_base_addr,
  input  logic [SRAM_ADDR_BITS-1:0] cfg_ot_rnd_finsub1,
  input  logic [7:0]                cfg_ot_round_finsub1,
  input  logic                      cfg_ot_mode,
  input  logic [BANK_IDX_BITS-1:0]  cfg_ot_bank
);

  localparam int unsigned RND_BITS = 8;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e                    state_q, state_d;
  logic [SRAM_ADDR_BITS-1:0] base_q, base_d;
  logic [SRAM_ADDR_BITS-1:0] rnd_fin_q, rnd_fin_d;
  logic [RND_BITS-1:0]       round_fin_q, round_fin_d;
  logic                      mode_q, mode_d;
  logic [BANK_IDX_BITS-1:0]  bank_q, bank_d;
  logic [SRAM_ADDR_BITS-1:0] entry_q, entry_d;
  logic [RND_BITS-1:0]       round_q, round_d;
  logic                      final_acc_q, final_acc_d;
  logic                      done_q, done_d;
  logic [NUM_BANK-1:0]       cen_q, cen_d;
  logic [NUM_BANK-1:0]       wen_q, wen_d;
  logic [SRAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [SRAM_DATA_BITS-1:0] data_q, data_d;
  logic                      last_q, last_d;

  logic                      entry_last;
  logic                      job_last;
  logic [BANK_IDX_BITS-1:0]  cur_bank;
  logic [NUM_BANK-1:0]       bank_oh;

  // Pop strobe is combinational so the FWFT head word is consumed in the same cycle.
  assign fifo_read  = (state_q == RUN) & fifo_empty_n & ~final_acc_q;
  assign entry_last = (entry_q == rnd_fin_q);
  assign job_last   = entry_last & (round_q == round_fin_q);
  assign cur_bank   = mode_q ? BANK_IDX_BITS'(bank_q + round_q[BANK_IDX_BITS-1:0]) : bank_q;
  assign bank_oh    = NUM_BANK'(1) << cur_bank;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    rnd_fin_d   = rnd_fin_q;
    round_fin_d = round_fin_q;
    mode_d      = mode_q;
    bank_d      = bank_q;
    entry_d     = entry_q;
    round_d     = round_q;
    final_acc_d = final_acc_q;
    done_d      = (state_q == FIN);
    cen_d       = '1;
    wen_d       = '1;
    addr_d      = addr_q;
    data_d      = '0;
    last_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          base_d      = cfg_ot_base_addr;
          rnd_fin_d   = cfg_ot_rnd_finsub1;
          round_fin_d = cfg_ot_round_finsub1;
          mode_d      = cfg_ot_mode;
          bank_d      = cfg_ot_bank;
          entry_d     = '0;
          round_d     = '0;
          final_acc_d = 1'b0;
        end
      end
      RUN: begin
        if (fifo_read) begin
          if (entry_last) begin
            entry_d = '0;
            round_d = round_q + RND_BITS'(1);
          end else begin
            entry_d = entry_q + SRAM_ADDR_BITS'(1);
          end
          if (job_last) begin
            final_acc_d = 1'b1;
            state_d     = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Write stage: register the accepted word for presentation next cycle.
    if (fifo_read) begin
      cen_d  = ~bank_oh;
      wen_d  = ~bank_oh;
      addr_d = base_q + entry_q;
      data_d = data_in;
      last_d = entry_last;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      rnd_fin_q   <= '0;
      round_fin_q <= '0;
      mode_q      <= 1'b0;
      bank_q      <= '0;
      entry_q     <= '0;
      round_q     <= '0;
      final_acc_q <= 1'b0;
      done_q      <= 1'b0;
      cen_q       <= '1;
      wen_q       <= '1;
      addr_q      <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      rnd_fin_q   <= rnd_fin_d;
      round_fin_q <= round_fin_d;
      mode_q      <= mode_d;
      bank_q      <= bank_d;
      entry_q     <= entry_d;
      round_q     <= round_d;
      final_acc_q <= final_acc_d;
      done_q      <= done_d;
      cen_q       <= cen_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      last_q      <= last_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign cen_otsr      = cen_q;
  assign wen_otsr      = wen_q;
  assign addr_otsr     = addr_q;
  assign data_for_sram = data_q;
  assign last          = last_q;

endmodule

// File: tb/tb_ot_write_mb.sv
// Directed self-checking bench for ot_write_mb: FIFO model, write-port logger,
// hand-computed expected writes per job.
module tb_ot_write_mb;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [63:0] data_in;
  logic        fifo_empty_n;
  logic        fifo_read;
  logic [1:0]  cen_otsr;
  logic [1:0]  wen_otsr;
  logic [9:0]  addr_otsr;
  logic [63:0] data_for_sram;
  logic        last;
  logic [9:0]  cfg_ot_base_addr;
  logic [9:0]  cfg_ot_rnd_finsub1;
  logic [7:0]  cfg_ot_round_finsub1;
  logic        cfg_ot_mode;
  logic [0:0]  cfg_ot_bank;

  ot_write_mb #(
    .SRAM_DATA_BITS(64), .SRAM_ADDR_BITS(10), .NUM_BANK(2), .BANK_IDX_BITS(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .data_in(data_in), .fifo_empty_n(fifo_empty_n), .fifo_read(fifo_read),
    .cen_otsr(cen_otsr), .wen_otsr(wen_otsr), .addr_otsr(addr_otsr),
    .data_for_sram(data_for_sram), .last(last),
    .cfg_ot_base_addr(cfg_ot_base_addr), .cfg_ot_rnd_finsub1(cfg_ot_rnd_finsub1),
    .cfg_ot_round_finsub1(cfg_ot_round_finsub1), .cfg_ot_mode(cfg_ot_mode),
    .cfg_ot_bank(cfg_ot_bank)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc;
  int          idle_bad;
  int          empty_read_bad;
  bit          gate_mode;
  logic [63:0] fq[$];
  int          rd_cyc[$];
  int          done_cyc[$];
  int          wr_cyc[$];
  int          wr_bank[$];
  logic [9:0]  wr_addr[$];
  logic [63:0] wr_data[$];
  bit          wr_last[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Log the write port at the falling edge; flag any malformed idle/write cycle.
  task automatic sample();
    int nz = 0;
    int b = 0;
    if (cen_otsr != 2'b11) begin
      for (int i = 0; i < 2; i++) if (!cen_otsr[i]) begin nz++; b = i; end
      if (nz != 1 || wen_otsr != cen_otsr) idle_bad++;
      wr_cyc.push_back(cyc);
      wr_bank.push_back(b);
      wr_addr.push_back(addr_otsr);
      wr_data.push_back(data_for_sram);
      wr_last.push_back(last);
    end else if (wen_otsr != 2'b11 || data_for_sram != 64'h0 || last) begin
      idle_bad++;
    end
    if (done) begin
      done_cyc.push_back(cyc);
      if (busy) idle_bad++;
    end
  endtask

  // One clock cycle, entered and left just after the rising edge.
  task automatic step();
    logic rd;
    fifo_empty_n = (fq.size() > 0) && (gate_mode == 1'b0 || (cyc % 3) == 1);
    data_in      = (fq.size() > 0) ? fq[0] : 64'h0;
    #1;
    rd = fifo_read;
    if (rd) rd_cyc.push_back(cyc);
    if (rd && !fifo_empty_n) empty_read_bad++;
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    if (rd) fq.delete(0);
    cyc++;
  endtask

  task automatic set_cfg(input bit mode, input bit bank, input logic [9:0] base,
                         input logic [9:0] rnd, input logic [7:0] rounds);
    cfg_ot_mode          = mode;
    cfg_ot_bank          = bank;
    cfg_ot_base_addr     = base;
    cfg_ot_rnd_finsub1   = rnd;
    cfg_ot_round_finsub1 = rounds;
  endtask

  task automatic load_fifo(input logic [63:0] first, input int n);
    fq.delete();
    for (int i = 0; i < n; i++) fq.push_back(first + 64'(i));
  endtask

  // Start pulse in cycle 0; run until a few cycles past done or the cycle budget.
  task automatic run_job(input int max_cyc, input bit disturb);
    rd_cyc.delete(); done_cyc.delete(); wr_cyc.delete(); wr_bank.delete();
    wr_addr.delete(); wr_data.delete(); wr_last.delete();
    cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < max_cyc && !(done_cyc.size() > 0 && cyc > done_cyc[0] + 2)) begin
      if (disturb && cyc == 3) begin
        start            = 1'b1;
        cfg_ot_base_addr = 10'h200;
        cfg_ot_bank      = 1'b0;
        cfg_ot_mode      = 1'b1;
      end
      step();
      start = 1'b0;
    end
  endtask

  task automatic check_wr(input string tag, input int i, input int ecyc, input int ebank,
                          input logic [9:0] eaddr, input logic [63:0] edata, input bit elast);
    if (i >= wr_cyc.size()) begin
      check($sformatf("%s_w%0d_missing", tag, i), 64'(wr_cyc.size()), 64'(i + 1));
    end else begin
      if (ecyc >= 0) check($sformatf("%s_w%0d_cyc", tag, i), 64'(wr_cyc[i]), 64'(ecyc));
      check($sformatf("%s_w%0d_bank", tag, i), 64'(wr_bank[i]), 64'(ebank));
      check($sformatf("%s_w%0d_addr", tag, i), 64'(wr_addr[i]), 64'(eaddr));
      check($sformatf("%s_w%0d_data", tag, i), wr_data[i], edata);
      check($sformatf("%s_w%0d_last", tag, i), 64'(wr_last[i]), 64'(elast));
    end
  endtask

  task automatic check_done(input string tag, input int nwr, input int edone);
    check({tag, "_nwr"}, 64'(wr_cyc.size()), 64'(nwr));
    check({tag, "_ndone"}, 64'(done_cyc.size()), 64'd1);
    if (done_cyc.size() > 0) check({tag, "_done_cyc"}, 64'(done_cyc[0]), 64'(edone));
    check({tag, "_npop"}, 64'(rd_cyc.size()), 64'(nwr));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; fifo_empty_n = 1'b0; data_in = 64'h0;
    gate_mode = 1'b0; idle_bad = 0; empty_read_bad = 0; cyc = 0;
    set_cfg(1'b0, 1'b0, 10'h0, 10'h0, 8'h0);
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_fifo_read", 64'(fifo_read), 64'd0);
    check("rst_last", 64'(last), 64'd0);
    check("rst_cen", 64'(cen_otsr), 64'h3);
    check("rst_wen", 64'(wen_otsr), 64'h3);
    check("rst_addr", 64'(addr_otsr), 64'h0);
    check("rst_data", data_for_sram, 64'h0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Test 1: fixed bank 1, 4 entries, 1 round
    set_cfg(1'b0, 1'b1, 10'h010, 10'd3, 8'd0);
    load_fifo(64'hA0, 8);
    run_job(40, 1'b0);
    for (int i = 0; i < 4; i++)
      check_wr("t1", i, i + 2, 1, 10'h010 + 10'(i), 64'hA0 + 64'(i), i == 3);
    for (int i = 0; i < 4 && i < rd_cyc.size(); i++)
      check($sformatf("t1_rd%0d_cyc", i), 64'(rd_cyc[i]), 64'(i + 1));
    check_done("t1", 4, 6);

    // Test 2: ping-pong from bank 0, 2 entries x 3 rounds
    set_cfg(1'b1, 1'b0, 10'h000, 10'd1, 8'd2);
    load_fifo(64'hB0, 6);
    run_job(40, 1'b0);
    for (int i = 0; i < 6; i++)
      check_wr("t2", i, i + 2, (i / 2) % 2, 10'(i % 2), 64'hB0 + 64'(i), (i % 2) == 1);
    check_done("t2", 6, 8);

    // Test 3: FIFO non-empty one cycle in three; 7th word must stay in the FIFO
    gate_mode = 1'b1;
    set_cfg(1'b0, 1'b0, 10'h020, 10'd2, 8'd1);
    load_fifo(64'hC0, 7);
    run_job(80, 1'b0);
    gate_mode = 1'b0;
    for (int i = 0; i < 6; i++)
      check_wr("t3", i, 3 * i + 2, 0, 10'h020 + 10'(i % 3), 64'hC0 + 64'(i), (i % 3) == 2);
    check_done("t3", 6, 18);
    check("t3_fifo_left", 64'(fq.size()), 64'd1);
    check("t3_pop_when_empty", 64'(empty_read_bad), 64'd0);

    // Test 4: address wrap past the top of the SRAM
    set_cfg(1'b0, 1'b0, 10'h3FE, 10'd3, 8'd0);
    load_fifo(64'hE0, 4);
    run_job(40, 1'b0);
    check_wr("t4", 0, 2, 0, 10'h3FE, 64'hE0, 1'b0);
    check_wr("t4", 1, 3, 0, 10'h3FF, 64'hE1, 1'b0);
    check_wr("t4", 2, 4, 0, 10'h000, 64'hE2, 1'b0);
    check_wr("t4", 3, 5, 0, 10'h001, 64'hE3, 1'b1);
    check_done("t4", 4, 6);

    // Test 5: start and cfg changes during RUN must be ignored
    set_cfg(1'b0, 1'b1, 10'h100, 10'd3, 8'd1);
    load_fifo(64'hF0, 8);
    run_job(40, 1'b1);
    for (int i = 0; i < 8; i++)
      check_wr("t5", i, i + 2, 1, 10'h100 + 10'(i % 4), 64'hF0 + 64'(i), (i % 4) == 3);
    check_done("t5", 8, 10);

    // Test 6: reset mid-round 1, then a fresh ping-pong job from bank 1
    set_cfg(1'b0, 1'b0, 10'h000, 10'd3, 8'd1);
    load_fifo(64'h50, 8);
    run_job(6, 1'b0);
    check("t6_pre_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_cen", 64'(cen_otsr), 64'h3);
    check("t6_rst_wen", 64'(wen_otsr), 64'h3);
    check("t6_rst_fifo_read", 64'(fifo_read), 64'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    set_cfg(1'b1, 1'b1, 10'h030, 10'd1, 8'd1);
    load_fifo(64'hD0, 4);
    run_job(40, 1'b0);
    for (int i = 0; i < 4; i++)
      check_wr("t6", i, i + 2, (i < 2) ? 1 : 0, 10'h030 + 10'(i % 2), 64'hD0 + 64'(i), (i % 2) == 1);
    check_done("t6", 4, 6);

    check("idle_port_clean", 64'(idle_bad), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
